// File: rtl/fcore_writeback_unit.sv
// fcore_writeback_unit
// Register-file writeback stage behind the fCore floating point ALU.
// It merges two sources onto one register-file write port:
// - ALU results have strict priority and are never stalled.
// - Auxiliary writes (load/IO/DMA) are buffered in a small FIFO.
// The FIFO head drains only in cycles with no unfiltered ALU transfer.
// Writes to r0 are dropped when PROTECT_R0 is set.
// The committed write is mirrored on the forwarding port from the same register.

module fcore_writeback_unit #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH  = 8,
  parameter int unsigned AUX_FIFO_DEPTH  = 4,
  parameter int unsigned PROTECT_R0      = 1,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             alu_data,
  input  logic [REG_ADDR_WIDTH-1:0]         alu_dest,
  input  logic                              alu_valid,
  input  logic [DATA_WIDTH-1:0]             aux_data,
  input  logic [REG_ADDR_WIDTH-1:0]         aux_dest,
  input  logic                              aux_valid,
  output logic                              aux_ready,
  output logic                              wr_en,
  output logic [REG_ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0]         fwd_addr,
  output logic [DATA_WIDTH-1:0]             fwd_data,
  output logic [$clog2(AUX_FIFO_DEPTH):0]   fifo_level,
  output logic [STALL_CNT_WIDTH-1:0]        aux_stall_cycles
);

  localparam int unsigned PTR_W = (AUX_FIFO_DEPTH > 1) ? $clog2(AUX_FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(AUX_FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(AUX_FIFO_DEPTH);
  localparam logic [LVL_W-1:0] ONE_LVL   = LVL_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
  localparam logic [STALL_CNT_WIDTH-1:0] ONE_CNT = STALL_CNT_WIDTH'(1);

  // True when a write to this address must be discarded (protected r0).
  function automatic logic is_protected(input logic [REG_ADDR_WIDTH-1:0] addr);
    return (PROTECT_R0 != 32'd0) && (addr == {REG_ADDR_WIDTH{1'b0}});
  endfunction

  // Auxiliary FIFO storage; contents need no reset because the level gates every read.
  logic [DATA_WIDTH-1:0]     data_mem_q [AUX_FIFO_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] dest_mem_q [AUX_FIFO_DEPTH];

  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  logic                       wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;

  logic                       alu_xfer;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic                       head_drop;
  logic [DATA_WIDTH-1:0]      head_data;
  logic [REG_ADDR_WIDTH-1:0]  head_dest;

  // Handshake and arbitration decode; only aux_ready sees reset combinationally.
  always_comb begin
    aux_ready  = (level_q < DEPTH_LVL) && !reset;
    alu_xfer   = alu_valid && !is_protected(alu_dest);
    fifo_empty = (level_q == {LVL_W{1'b0}});
    push       = aux_valid && aux_ready;
    pop        = !alu_xfer && !fifo_empty;
    head_data  = data_mem_q[rd_ptr_q];
    head_dest  = dest_mem_q[rd_ptr_q];
    head_drop  = is_protected(head_dest);
  end

  // Next-state for the write port: ALU first, then a non-r0 FIFO head, else idle zeros.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = {REG_ADDR_WIDTH{1'b0}};
    wr_data_d = {DATA_WIDTH{1'b0}};
    if (alu_xfer) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_dest;
      wr_data_d = alu_data;
    end else if (pop && !head_drop) begin
      wr_en_d   = 1'b1;
      wr_addr_d = head_dest;
      wr_data_d = head_data;
    end else begin
      wr_en_d   = 1'b0;
    end
  end

  // Next-state for FIFO pointers and occupancy; pointers wrap on power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + ONE_LVL;
      2'b01:   level_d = level_q - ONE_LVL;
      default: level_d = level_q;
    endcase
  end

  // Next-state for the saturating aux stall counter.
  always_comb begin
    stall_d = stall_q;
    if (aux_valid && !aux_ready && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + ONE_CNT;
    end else begin
      stall_d = stall_q;
    end
  end

  // FIFO storage write on an accepted aux push.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= aux_data;
      dest_mem_q[wr_ptr_q] <= aux_dest;
    end
  end

  // State registers; reset empties the FIFO and discards any write in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      level_q   <= {LVL_W{1'b0}};
      stall_q   <= {STALL_CNT_WIDTH{1'b0}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= {REG_ADDR_WIDTH{1'b0}};
      wr_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      stall_q   <= stall_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Forwarding is a copy of the same registered write, so it can never disagree with wr_*.
  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign fwd_valid        = wr_en_q;
  assign fwd_addr         = wr_addr_q;
  assign fwd_data         = wr_data_q;
  assign fifo_level       = level_q;
  assign aux_stall_cycles = stall_q;

endmodule

// File: tb/tb_fcore_writeback_unit.sv
// Directed self-checking bench for fcore_writeback_unit.
// The stall counter is narrowed to 4 bits so that saturation is reachable quickly.
`timescale 1ns/1ps

module tb_fcore_writeback_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SCW = 4;

  logic          clock;
  logic          reset;
  logic [DW-1:0] alu_data;
  logic [AW-1:0] alu_dest;
  logic          alu_valid;
  logic [DW-1:0] aux_data;
  logic [AW-1:0] aux_dest;
  logic          aux_valid;
  logic          aux_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic [2:0]    fifo_level;
  logic [SCW-1:0] aux_stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  fcore_writeback_unit #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .AUX_FIFO_DEPTH(DEPTH),
    .PROTECT_R0(1), .STALL_CNT_WIDTH(SCW)
  ) dut (
    .clock(clock), .reset(reset),
    .alu_data(alu_data), .alu_dest(alu_dest), .alu_valid(alu_valid),
    .aux_data(aux_data), .aux_dest(aux_dest), .aux_valid(aux_valid),
    .aux_ready(aux_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .fifo_level(fifo_level), .aux_stall_cycles(aux_stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    chk({tag, ".wr_en"},     64'(wr_en),     64'(en));
    chk({tag, ".wr_addr"},   64'(wr_addr),   64'(addr));
    chk({tag, ".wr_data"},   64'(wr_data),   64'(data));
    chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(en));
    chk({tag, ".fwd_addr"},  64'(fwd_addr),  64'(addr));
    chk({tag, ".fwd_data"},  64'(fwd_data),  64'(data));
  endtask

  task automatic set_alu(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x);
    alu_valid = v;
    alu_dest  = d;
    alu_data  = x;
  endtask

  task automatic set_aux(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x);
    aux_valid = v;
    aux_dest  = d;
    aux_data  = x;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_alu(1'b0, 8'd0, 32'd0);
    set_aux(1'b0, 8'd0, 32'd0);
    tick();
    tick();

    // Reset state
    chk_wr("rst", 1'b0, 8'd0, 32'd0);
    chk("rst.level", 64'(fifo_level), 64'd0);
    chk("rst.stall", 64'(aux_stall_cycles), 64'd0);
    chk("rst.ready", 64'(aux_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst.ready_after", 64'(aux_ready), 64'd1);

    // Single ALU write, 1-cycle latency
    set_alu(1'b1, 8'd5, 32'h3F80_0000);
    tick();
    chk_wr("t1.alu", 1'b1, 8'd5, 32'h3F80_0000);
    set_alu(1'b0, 8'd0, 32'd0);
    tick();
    chk_wr("t1.idle", 1'b0, 8'd0, 32'd0);

    // ALU r0 writes are dropped and yield the slot to the buffered aux entry
    set_alu(1'b1, 8'd0, 32'hDEAD_BEEF);
    set_aux(1'b1, 8'd7, 32'h4000_0000);
    tick();
    chk_wr("t2.r0drop", 1'b0, 8'd0, 32'd0);
    chk("t2.level1", 64'(fifo_level), 64'd1);
    set_aux(1'b0, 8'd0, 32'd0);
    tick();
    chk_wr("t2.aux", 1'b1, 8'd7, 32'h4000_0000);
    chk("t2.level0", 64'(fifo_level), 64'd0);
    set_alu(1'b0, 8'd0, 32'd0);
    tick();
    chk_wr("t2.idle", 1'b0, 8'd0, 32'd0);

    // Continuous ALU traffic; 6 aux offers, only 4 fit
    for (int i = 0; i < 10; i++) begin
      set_alu(1'b1, 8'(10 + i), 32'(i));
      if (i < 4) set_aux(1'b1, 8'(20 + i), 32'(32'hA0 + i));
      else if (i < 6) set_aux(1'b1, 8'd24, 32'hA4);
      else set_aux(1'b0, 8'd0, 32'd0);
      if (i < 6) chk($sformatf("t3.ready%0d", i), 64'(aux_ready), 64'(i < 4));
      tick();
      chk_wr($sformatf("t3.alu%0d", i), 1'b1, 8'(10 + i), 32'(i));
    end
    chk("t3.stall", 64'(aux_stall_cycles), 64'd2);
    chk("t3.level", 64'(fifo_level), 64'd4);
    set_alu(1'b0, 8'd0, 32'd0);
    set_aux(1'b0, 8'd0, 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_wr($sformatf("t3.drain%0d", j), 1'b1, 8'(20 + j), 32'(32'hA0 + j));
    end
    tick();
    chk_wr("t3.idle", 1'b0, 8'd0, 32'd0);
    chk("t3.empty", 64'(fifo_level), 64'd0);

    // Full FIFO: pop and offer in the same cycle refuses the push
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 8'd1, 32'(32'h100 + i));
      set_aux(1'b1, 8'(30 + i), 32'(32'h30 + i));
      tick();
    end
    chk("t4.full", 64'(fifo_level), 64'd4);
    chk_wr("t4.alu", 1'b1, 8'd1, 32'h103);
    set_alu(1'b0, 8'd0, 32'd0);
    set_aux(1'b1, 8'd34, 32'h34);
    #1;
    chk("t4.ready_full", 64'(aux_ready), 64'd0);
    tick();
    chk("t4.level3", 64'(fifo_level), 64'd3);
    chk_wr("t4.pop", 1'b1, 8'd30, 32'h30);
    chk("t4.stall", 64'(aux_stall_cycles), 64'd3);
    set_alu(1'b1, 8'd2, 32'h222);
    #1;
    chk("t4.ready_again", 64'(aux_ready), 64'd1);
    tick();
    chk("t4.level4", 64'(fifo_level), 64'd4);
    chk_wr("t4.alu2", 1'b1, 8'd2, 32'h222);
    set_alu(1'b0, 8'd0, 32'd0);
    set_aux(1'b0, 8'd0, 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_wr($sformatf("t4.drain%0d", j), 1'b1, 8'(31 + j), 32'(32'h31 + j));
    end
    tick();
    chk_wr("t4.idle", 1'b0, 8'd0, 32'd0);
    chk("t4.empty", 64'(fifo_level), 64'd0);

    // Empty FIFO, single aux write: commit at +2, not +1
    set_aux(1'b1, 8'd12, 32'h1234_5678);
    tick();
    chk_wr("t5.plus1", 1'b0, 8'd0, 32'd0);
    chk("t5.level", 64'(fifo_level), 64'd1);
    set_aux(1'b0, 8'd0, 32'd0);
    tick();
    chk_wr("t5.plus2", 1'b1, 8'd12, 32'h1234_5678);
    tick();
    chk_wr("t5.idle", 1'b0, 8'd0, 32'd0);

    // Aux entry to r0 is accepted but dropped at pop; next entry follows
    set_aux(1'b1, 8'd0, 32'h0BAD_0000);
    tick();
    chk_wr("t6.push0", 1'b0, 8'd0, 32'd0);
    set_aux(1'b1, 8'd9, 32'h9999_0009);
    tick();
    chk_wr("t6.drop0", 1'b0, 8'd0, 32'd0);
    chk("t6.level_same", 64'(fifo_level), 64'd1);
    set_aux(1'b0, 8'd0, 32'd0);
    tick();
    chk_wr("t6.aux9", 1'b1, 8'd9, 32'h9999_0009);
    chk("t6.empty", 64'(fifo_level), 64'd0);

    // Stall counter saturation
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 8'd1, 32'(i));
      set_aux(1'b1, 8'(50 + i), 32'(32'h50 + i));
      tick();
    end
    set_aux(1'b1, 8'd54, 32'h54);
    for (int i = 0; i < 12; i++) tick();
    chk("t7.stall15", 64'(aux_stall_cycles), 64'd15);
    tick();
    tick();
    chk("t7.stall_sat", 64'(aux_stall_cycles), 64'd15);
    chk("t7.full", 64'(fifo_level), 64'd4);
    set_alu(1'b0, 8'd0, 32'd0);
    set_aux(1'b0, 8'd0, 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_wr($sformatf("t7.drain%0d", j), 1'b1, 8'(50 + j), 32'(32'h50 + j));
    end
    tick();
    chk("t7.empty", 64'(fifo_level), 64'd0);

    // Reset with 3 buffered entries and a write in flight
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, 8'd3, 32'(i));
      set_aux(1'b1, 8'(40 + i), 32'(32'h40 + i));
      tick();
    end
    chk("t8.level3", 64'(fifo_level), 64'd3);
    set_alu(1'b1, 8'd4, 32'h44);
    set_aux(1'b0, 8'd0, 32'd0);
    reset = 1'b1;
    tick();
    chk_wr("t8.rst", 1'b0, 8'd0, 32'd0);
    chk("t8.level0", 64'(fifo_level), 64'd0);
    chk("t8.stall0", 64'(aux_stall_cycles), 64'd0);
    chk("t8.ready_rst", 64'(aux_ready), 64'd0);
    reset = 1'b0;
    set_alu(1'b0, 8'd0, 32'd0);
    #1;
    chk("t8.ready_after", 64'(aux_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t8.nostale%0d", i), 64'(wr_en), 64'd0);
    end
    chk("t8.empty", 64'(fifo_level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
